ibutterfly_pipe_32b: RTL and testbench

//  Pipelined radix-2 decimation-in-frequency inverse butterfly for the 32-point, 32-bit IFFT path.

---
 rtl/ibutterfly_pipe_32b.sv | 157 +++++++++++++++
 tb/tb_ibutterfly_pipe_32b.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibutterfly_pipe_32b.sv
// ibutterfly_pipe_32b: 3-stage radix-2 DIF inverse butterfly, dout0=(a+b)/2, dout1=((a-b)*conj(w))/2.
// Build option IBFLY_SAT_EN: saturate the final narrowing instead of wrapping; ovf is sticky either way.
module ibutterfly_pipe_32b #(
  parameter int unsigned DW   = 32,
  parameter int unsigned TW   = 32,
  parameter int unsigned FRAC = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din0_real,
  input  logic [DW-1:0] din0_imag,
  input  logic [DW-1:0] din1_real,
  input  logic [DW-1:0] din1_imag,
  input  logic [TW-1:0] w_real,
  input  logic [TW-1:0] w_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout0_real,
  output logic [DW-1:0] dout0_imag,
  output logic [DW-1:0] dout1_real,
  output logic [DW-1:0] dout1_imag,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam int unsigned SW = DW + 1;     // sum/difference width
  localparam int unsigned MW = SW + TW;    // single product width
  localparam int unsigned PW = MW + 1;     // sum of two products
  localparam int unsigned SH = FRAC + 1;   // twiddle scaling plus the 1/2 stage scaling
  localparam int unsigned NW = PW - SH;    // pre-narrowing result width

  // True when x is representable as a DW-bit signed value.
  function automatic logic fits(input logic signed [NW-1:0] x);
    return x[NW-1:DW-1] == {(NW-DW+1){x[DW-1]}};
  endfunction

  function automatic logic [DW-1:0] narrow(input logic signed [NW-1:0] x);
`ifdef IBFLY_SAT_EN
    if (!fits(x)) begin
      return x[NW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
`endif
    return x[DW-1:0];
  endfunction

  logic adv;

  logic signed [SW-1:0] a_r, a_i, b_r, b_i;

  logic                 s1_v;
  logic signed [SW-1:0] s1_sr, s1_si, s1_dr, s1_di;
  logic signed [TW-1:0] s1_wr, s1_wi;

  logic signed [MW-1:0] m_rr, m_ii, m_ir, m_ri;

  logic                 s2_v;
  logic signed [SW-1:0] s2_sr, s2_si;
  logic signed [PW-1:0] s2_pr, s2_pi;

  logic signed [NW-1:0] x0_r, x0_i, x1_r, x1_i;
  logic                 of_any;

  // Whole pipe advances as one; a stalled output freezes every stage.
  always_comb begin
    adv = !out_valid || out_ready;
    a_r = SW'(signed'(din0_real));
    a_i = SW'(signed'(din0_imag));
    b_r = SW'(signed'(din1_real));
    b_i = SW'(signed'(din1_imag));
  end

  assign in_ready = adv;

  // S1: sum and difference at full width, capture twiddle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s1_sr <= '0;
      s1_si <= '0;
      s1_dr <= '0;
      s1_di <= '0;
      s1_wr <= '0;
      s1_wi <= '0;
    end else if (adv) begin
      s1_v  <= in_valid;
      s1_sr <= a_r + b_r;
      s1_si <= a_i + b_i;
      s1_dr <= a_r - b_r;
      s1_di <= a_i - b_i;
      s1_wr <= signed'(w_real);
      s1_wi <= signed'(w_imag);
    end
  end

  // Complex multiply by the conjugate twiddle: (dr + j di)(wr - j wi).
  always_comb begin
    m_rr = MW'(s1_dr) * MW'(s1_wr);
    m_ii = MW'(s1_di) * MW'(s1_wi);
    m_ir = MW'(s1_di) * MW'(s1_wr);
    m_ri = MW'(s1_dr) * MW'(s1_wi);
  end

  // S2: full-precision product sums, carry the sum forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v  <= 1'b0;
      s2_sr <= '0;
      s2_si <= '0;
      s2_pr <= '0;
      s2_pi <= '0;
    end else if (adv) begin
      s2_v  <= s1_v;
      s2_sr <= s1_sr;
      s2_si <= s1_si;
      s2_pr <= PW'(m_rr) + PW'(m_ii);
      s2_pi <= PW'(m_ir) - PW'(m_ri);
    end
  end

  // Arithmetic right shifts round toward -inf; results still carry guard bits for the range check.
  always_comb begin
    x0_r   = NW'(s2_sr >>> 1);
    x0_i   = NW'(s2_si >>> 1);
    x1_r   = NW'(s2_pr >>> SH);
    x1_i   = NW'(s2_pi >>> SH);
    of_any = !fits(x0_r) || !fits(x0_i) || !fits(x1_r) || !fits(x1_i);
  end

  // S3: narrowed output registers and the sticky overflow flag (a new overflow beats a clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      dout0_real <= '0;
      dout0_imag <= '0;
      dout1_real <= '0;
      dout1_imag <= '0;
      ovf        <= 1'b0;
    end else begin
      if (adv) begin
        out_valid  <= s2_v;
        dout0_real <= narrow(x0_r);
        dout0_imag <= narrow(x0_i);
        dout1_real <= narrow(x1_r);
        dout1_imag <= narrow(x1_i);
      end
      if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (adv && s2_v && of_any) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ibutterfly_pipe_32b.sv
// Scoreboard bench for ibutterfly_pipe_32b: directed vectors with hand-computed results.
module tb_ibutterfly_pipe_32b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din0_real, din0_imag, din1_real, din1_imag;
  logic [31:0] w_real, w_imag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout0_real, dout0_imag, dout1_real, dout1_imag;
  logic        ovf;
  logic        ovf_clr;

  typedef struct {
    logic [31:0] a_r, a_i, b_r, b_i, w_r, w_i;
    logic [31:0] e0r, e0i, e1r, e1i;
    logic        eovf;
  } vec_t;

  typedef struct {
    logic [31:0] d0r, d0i, d1r, d1i;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  ibutterfly_pipe_32b dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din0_real  (din0_real),
    .din0_imag  (din0_imag),
    .din1_real  (din1_real),
    .din1_imag  (din1_imag),
    .w_real     (w_real),
    .w_imag     (w_imag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dout0_real (dout0_real),
    .dout0_imag (dout0_imag),
    .dout1_real (dout1_real),
    .dout1_imag (dout1_imag),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a_r, a_i, b_r, b_i, w_r, w_i,
                              input logic [31:0] e0r, e0i, e1r, e1i, input logic eovf);
    vec_t v;
    v.a_r = a_r; v.a_i = a_i; v.b_r = b_r; v.b_i = b_i; v.w_r = w_r; v.w_i = w_i;
    v.e0r = e0r; v.e0i = e0i; v.e1r = e1r; v.e1i = e1i; v.eovf = eovf;
    return v;
  endfunction

  // w = 1.0; a=(16k+1,-4k), b=(2k,6) -> dout0=(9k,3-2k), dout1=(7k,-2k-3)
  function automatic vec_t stream(input int k);
    return mk(32'(16*k+1), 32'(-4*k), 32'(2*k), 32'd6, 32'h4000_0000, 32'd0,
              32'(9*k), 32'(3-2*k), 32'(7*k), 32'(-2*k-3), 1'b0);
  endfunction

  task automatic drive(input vec_t v);
    in_valid  = 1'b1;
    din0_real = v.a_r; din0_imag = v.a_i;
    din1_real = v.b_r; din1_imag = v.b_i;
    w_real    = v.w_r; w_imag    = v.w_i;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.d0r = v.e0r; e.d0i = v.e0i; e.d1r = v.e1r; e.d1i = v.e1i; e.ovf = v.eovf;
    sb.push_back(e);
  endtask

  // Present one butterfly; the transfer happens on the next rising edge once in_ready is seen.
  task automatic send(input vec_t v);
    int n;
    @(negedge clk);
    drive(v);
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=0 required=1");
    end else begin
      push_exp(v);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops on every output transfer and checks hold-while-stalled.
  initial begin : monitor
    exp_t        e;
    logic        stalled;
    logic [31:0] h0r, h0i, h1r, h1i;
    stalled = 1'b0;
    h0r = '0; h0i = '0; h1r = '0; h1i = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_hold_valid", 32'(out_valid), 32'd1);
          check("stall_hold_d0r", dout0_real, h0r);
          check("stall_hold_d0i", dout0_imag, h0i);
          check("stall_hold_d1r", dout1_real, h1r);
          check("stall_hold_d1i", dout1_imag, h1i);
        end
        if (out_valid && !out_ready) begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output d0r=0x%08h required=no_output", dout0_real);
          end else begin
            e = sb.pop_front();
            check("dout0_real", dout0_real, e.d0r);
            check("dout0_imag", dout0_imag, e.d0i);
            check("dout1_real", dout1_real, e.d1r);
            check("dout1_imag", dout1_imag, e.d1i);
            check("ovf", 32'(ovf), 32'(e.ovf));
          end
        end
        stalled = out_valid && !out_ready;
        h0r = dout0_real; h0i = dout0_imag; h1r = dout1_real; h1i = dout1_imag;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation_time_exceeded required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t v_id, v_conj, v_negw, v_ovf, v_floor;
    bit   pat [10];
    v_id    = mk(32'd100, 32'd0, 32'd50, 32'd0, 32'h4000_0000, 32'd0,
                 32'd75, 32'd0, 32'd25, 32'd0, 1'b0);
    v_conj  = mk(32'd0, 32'd0, 32'd0, 32'd8, 32'd0, 32'h4000_0000,
                 32'd0, 32'd4, 32'hFFFF_FFFC, 32'd0, 1'b0);
    v_negw  = mk(32'h7FFF_FFFF, 32'd0, 32'h8000_0000, 32'd0, 32'hC000_0000, 32'd0,
                 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd0, 1'b0);
`ifdef IBFLY_SAT_EN
    v_ovf   = mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                 32'hC000_0000, 32'hC000_0000,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1);
`else
    v_ovf   = mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                 32'hC000_0000, 32'hC000_0000,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 1'b1);
`endif
    v_floor = mk(32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0, 32'h4000_0000, 32'd0,
                 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFE, 32'd0, 1'b0);
    pat = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    din0_real = '0; din0_imag = '0; din1_real = '0; din1_imag = '0;
    w_real = '0; w_imag = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_dout0_real", dout0_real, 32'd0);
    check("reset_dout1_imag", dout1_imag, 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Identity twiddle with a latency check: valid shows on the third edge only.
    send(v_id);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("t1_out_valid_timing", 32'(out_valid), 32'(c == 3));
    end
    drain();

    send(v_conj);
    send(v_negw);
    send(v_floor);
    idle();
    drain();
    check("no_ovf_before_overflow", 32'(ovf), 32'd0);

    send(v_ovf);
    idle();
    drain();
    check("ovf_sticky", 32'(ovf), 32'd1);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    #1;
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Back-to-back stream with out_ready low for cycles 4..7.
    fork
      begin
        for (int k = 0; k < 8; k++) send(stream(k));
        idle();
      end
      begin
        for (int c = 0; c < 12; c++) begin
          @(negedge clk);
          out_ready = !(c >= 4 && c <= 7);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Alternating bubbles: out_valid must echo the input pattern three cycles later.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i < 10 && pat[i]) drive(stream(i));
      else in_valid = 1'b0;
      #1;
      if (i < 10 && pat[i]) begin
        check("t6_in_ready", 32'(in_ready), 32'd1);
        push_exp(stream(i));
      end
      if (i >= 3) check("t6_out_valid_pattern", 32'(out_valid), 32'(pat[i-3]));
    end
    drain();

    send(v_ovf);
    idle();
    drain();

    // Reset with two butterflies in flight: they must vanish.
    @(negedge clk);
    drive(v_id);
    @(negedge clk);
    drive(v_conj);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_dout0_real", dout0_real, 32'd0);
    check("t5_rst_dout0_imag", dout0_imag, 32'd0);
    check("t5_rst_dout1_real", dout1_real, 32'd0);
    check("t5_rst_dout1_imag", dout1_imag, 32'd0);
    check("t5_rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      check("t5_no_output_after_reset", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
